// File: rtl/fifo_read_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_stream
// Purpose  : Converts a 1-cycle-latency FIFO read port into a valid/ready
//            stream. A 2-entry output buffer absorbs the read latency, which
//            allows a sustained 1 word/cycle with no bubbles under continuous
//            ready.
// Ports    : r_clk      - read-domain clock (rising edge)
//            r_rst      - synchronous active-high reset (shared with FIFO)
//            empty      - upstream FIFO empty flag
//            r_en       - read request to upstream FIFO
//            fifo_data  - upstream registered read data (valid 1 cycle
//                         after an issued read)
//            m_data     - stream data (head of output buffer)
//            m_valid    - stream valid
//            m_ready    - stream ready
//            buf_cnt    - output-buffer occupancy 0..2
//            rd_words   - 16-bit wrapping handshake counter (only when
//                         FIFO_RD_WORD_CNT_EN is defined)
// Options  : `define FIFO_RD_WORD_CNT_EN adds the rd_words port and counter.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_stream #(
    parameter int WIDTH = 8
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic             empty,
    output logic             r_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       buf_cnt
`ifdef FIFO_RD_WORD_CNT_EN
    ,
    output logic [15:0]      rd_words
`endif
);

    // Occupancy states
    localparam logic [1:0] BUF0 = 2'd0;
    localparam logic [1:0] BUF1 = 2'd1;
    localparam logic [1:0] BUF2 = 2'd2;

    logic [1:0]       r_state;
    logic             r_inflight;   // a read was issued last cycle
    logic [WIDTH-1:0] r_head;       // oldest buffered word
    logic [WIDTH-1:0] r_tail;       // second word, valid only in BUF2

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_head_nxt;
    logic [WIDTH-1:0] w_tail_nxt;
    logic             w_valid;
    logic             w_pop;
    logic             w_cap;
    logic [2:0]       w_level;

    // Outputs are forced idle while reset is held so that no handshake can
    // complete on the reset cycle and no read is requested.
    assign w_valid = (r_state != BUF0) && !r_rst;
    assign w_pop   = w_valid && m_ready;
    assign w_cap   = r_inflight;

    // Projected occupancy after this cycle's pop and pending capture. A new
    // read is allowed only if its word will still find a free slot.
    assign w_level = {1'b0, r_state} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign r_en    = !r_rst && !empty && (w_level < 3'd2);

    assign m_valid = w_valid;
    assign m_data  = r_rst ? '0 : r_head;
    assign buf_cnt = r_rst ? 2'd0 : r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            BUF0: begin
                if (w_cap) begin
                    w_head_nxt  = fifo_data;
                    w_state_nxt = BUF1;
                end
            end
            BUF1: begin
                case ({w_cap, w_pop})
                    2'b11: w_head_nxt = fifo_data;      // head replaced directly
                    2'b10: begin
                        w_tail_nxt  = fifo_data;
                        w_state_nxt = BUF2;
                    end
                    2'b01: w_state_nxt = BUF0;
                    default: w_state_nxt = BUF1;
                endcase
            end
            BUF2: begin
                // Capture without pop cannot occur here: r_en is withheld
                // whenever the buffer would overflow.
                if (w_pop) begin
                    w_head_nxt = r_tail;
                    if (w_cap) begin
                        w_tail_nxt = fifo_data;
                    end else begin
                        w_state_nxt = BUF1;
                    end
                end
            end
            default: w_state_nxt = BUF0;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_state    <= BUF0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= r_en;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
        end
    end

`ifdef FIFO_RD_WORD_CNT_EN
    logic [15:0] r_rd_words;

    // Natural 16-bit rollover gives the 0xFFFF -> 0x0000 wrap.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_rd_words <= 16'd0;
        end else if (w_pop) begin
            r_rd_words <= r_rd_words + 16'd1;
        end
    end

    assign rd_words = r_rd_words;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_stream
// Purpose  : Directed self-checking bench for fifo_read_stream. A small
//            behavioural FIFO with 1-cycle registered read data feeds the
//            design; popped words are recorded and compared with
//            hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_stream;

    logic       r_clk = 1'b0;
    logic       r_rst;
    logic       empty;
    logic       r_en;
    logic [7:0] fifo_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] buf_cnt;
`ifdef FIFO_RD_WORD_CNT_EN
    logic [15:0] rd_words;
`endif

    fifo_read_stream #(.WIDTH(8)) dut (
        .r_clk     (r_clk),
        .r_rst     (r_rst),
        .empty     (empty),
        .r_en      (r_en),
        .fifo_data (fifo_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .buf_cnt   (buf_cnt)
`ifdef FIFO_RD_WORD_CNT_EN
        ,
        .rd_words  (rd_words)
`endif
    );

    always #5 r_clk = ~r_clk;

    int errors = 0;
    int checks = 0;

    // Behavioural upstream FIFO
    logic [7:0] mem [0:15];
    int         fifo_len  = 0;
    int         rd_ptr    = 0;
    bit         stream_mode = 1'b0;

    // Recording
    logic [7:0] popq[$];
    int         popcyc[$];
    int         cycle;
    int         issued_cnt;
    int         first_ren;
    int         first_val;
    int         pop_cnt;
    logic       last_ren;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at 1 time unit after a rising edge; returns at the same phase
    // of the next cycle.
    task automatic tick();
        logic iss;
        #1;
        iss      = r_en && !empty;
        last_ren = r_en;
        if (r_en && first_ren < 0) first_ren = cycle;
        if (m_valid && first_val < 0) first_val = cycle;
        if (m_valid && m_ready) begin
            popq.push_back(m_data);
            popcyc.push_back(cycle);
            pop_cnt++;
        end
        if (iss) issued_cnt++;
        @(posedge r_clk);
        #1;
        if (iss) begin
            fifo_data = stream_mode ? rd_ptr[7:0] : mem[rd_ptr];
            rd_ptr++;
        end
        empty = stream_mode ? 1'b0 : (rd_ptr >= fifo_len);
        cycle++;
    endtask

    task automatic clear_rec();
        popq.delete();
        popcyc.delete();
        cycle      = 0;
        issued_cnt = 0;
        first_ren  = -1;
        first_val  = -1;
        pop_cnt    = 0;
    endtask

    task automatic load(input int n, input logic [7:0] start, input logic [7:0] step);
        logic [7:0] v;
        v = start;
        for (int i = 0; i < n; i++) begin
            mem[i] = v;
            v = v + step;
        end
        rd_ptr   = 0;
        fifo_len = n;
        empty    = (n == 0);
    endtask

    function automatic logic [7:0] popped(input int i);
        if (i < popq.size()) return popq[i];
        return 8'hxx;
    endfunction

    initial begin
        r_rst     = 1'b1;
        empty     = 1'b1;
        m_ready   = 1'b0;
        fifo_data = 8'h00;
        clear_rec();
        @(posedge r_clk);
        #1;

        // ---- Reset state ----
        tick();
        tick();
        chk("rst_r_en",    {31'd0, r_en},    32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_buf_cnt", {30'd0, buf_cnt}, 32'd0);
        chk("rst_m_data",  {24'd0, m_data},  32'd0);
        r_rst = 1'b0;

        // ---- Idle with empty FIFO for 10 cycles ----
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_r_en",    {31'd0, last_ren}, 32'd0);
            chk("idle_m_valid", {31'd0, m_valid},  32'd0);
            chk("idle_buf_cnt", {30'd0, buf_cnt},  32'd0);
        end

        // ---- 3 words, m_ready=1: 2-cycle latency, back-to-back output ----
        clear_rec();
        load(3, 8'h11, 8'h11);
        m_ready = 1'b1;
        repeat (5) tick();
        chk("lat_first_ren", first_ren, 32'd0);
        chk("lat_first_val", first_val, 32'd2);
        chk("lat_count",     popq.size(), 32'd3);
        chk("lat_w0", {24'd0, popped(0)}, 32'h11);
        chk("lat_w1", {24'd0, popped(1)}, 32'h22);
        chk("lat_w2", {24'd0, popped(2)}, 32'h33);
        chk("lat_c0", (popcyc.size() > 0) ? popcyc[0] : -1, 32'd2);
        chk("lat_c2", (popcyc.size() > 2) ? popcyc[2] : -1, 32'd4);
        // valid drops the cycle after the last pop
        chk("lat_valid_fall", {31'd0, m_valid}, 32'd0);

        // ---- 5 words, m_ready=0: buffer fills, reads stop ----
        clear_rec();
        load(5, 8'h01, 8'h01);
        m_ready = 1'b0;
        repeat (8) tick();
        chk("bp_issued",  issued_cnt, 32'd2);
        chk("bp_buf_cnt", {30'd0, buf_cnt},  32'd2);
        chk("bp_r_en",    {31'd0, last_ren}, 32'd0);
        chk("bp_m_valid", {31'd0, m_valid},  32'd1);
        chk("bp_m_data",  {24'd0, m_data},   32'h01);
        repeat (3) tick();
        chk("bp_hold",    {24'd0, m_data},   32'h01);
        clear_rec();
        m_ready = 1'b1;
        repeat (10) tick();
        chk("bp_drain_cnt", popq.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("bp_drain_w", {24'd0, popped(i)}, 32'h01 + i);

        // ---- 8 words with m_ready toggling 1,0,1,0 ----
        clear_rec();
        load(8, 8'hA0, 8'h01);
        for (int i = 0; i < 40; i++) begin
            m_ready = (i % 2 == 0);
            tick();
        end
        chk("tog_count", popq.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            chk("tog_w", {24'd0, popped(i)}, 32'hA0 + i);
        chk("tog_idle", {31'd0, m_valid}, 32'd0);

        // ---- Reset mid-operation: one word buffered, one in flight ----
        clear_rec();
        load(10, 8'hC0, 8'h01);
        m_ready = 1'b0;
        repeat (2) tick();
        chk("mrst_pre_cnt",  {30'd0, buf_cnt}, 32'd1);
        chk("mrst_pre_data", {24'd0, m_data},  32'hC0);
        r_rst    = 1'b1;
        fifo_len = rd_ptr;      // upstream FIFO shares the reset
        empty    = 1'b1;
        m_ready  = 1'b1;
        #1;
        chk("mrst_valid_in_rst", {31'd0, m_valid}, 32'd0);
        tick();
        r_rst = 1'b0;
        chk("mrst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mrst_buf_cnt", {30'd0, buf_cnt}, 32'd0);
        chk("mrst_m_data",  {24'd0, m_data},  32'd0);
        repeat (6) tick();
        chk("mrst_no_output", popq.size(), 32'd0);

        // ---- Resume after reset ----
        clear_rec();
        load(2, 8'hD0, 8'h01);
        m_ready = 1'b1;
        repeat (6) tick();
        chk("res_first_val", first_val, 32'd2);
        chk("res_count", popq.size(), 32'd2);
        chk("res_w0", {24'd0, popped(0)}, 32'hD0);
        chk("res_w1", {24'd0, popped(1)}, 32'hD1);

`ifdef FIFO_RD_WORD_CNT_EN
        // ---- Word counter wrap: 65537 handshakes -> 1 ----
        r_rst = 1'b1;
        empty = 1'b1;
        tick();
        r_rst = 1'b0;
        chk("cnt_reset", {16'd0, rd_words}, 32'd0);
        clear_rec();
        stream_mode = 1'b1;
        rd_ptr      = 0;
        empty       = 1'b0;
        m_ready     = 1'b1;
        for (int i = 0; i < 70000 && pop_cnt < 65537; i++) begin
            tick();
            if (popq.size() > 16) popq.delete();
        end
        chk("cnt_pops", pop_cnt, 32'd65537);
        chk("cnt_wrap", {16'd0, rd_words}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
